riscv_store_unit: RTL and testbench

Store path stage directly downstream of the rs2 store-data mask. It takes masked store data, the effective address and the store width, shifts the data into the correct byte lanes and generates byte strobes. It buffers accepted stores in a small FIFO and drains them to data memory over a req/ack handshake. It back-pressures the pipeline when full and flags misaligned or illegal stores.

---
 rtl/riscv_store_pkg.sv | 31 +++
 rtl/riscv_store_align.sv | 59 +++++
 rtl/riscv_store_unit.sv | 188 ++++++++++++++++++
 tb/tb_riscv_store_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_store_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_store_pkg
//  Description : Shared definitions for the store path: store width select
//                encoding, drain FSM states and byte-strobe constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_store_pkg;

  // Store width select as delivered by the rs2 store-data mask stage.
  localparam int MASK_SEL_W = 2;

  typedef enum logic [MASK_SEL_W-1:0] {
    MASK_B = 2'd0,
    MASK_H = 2'd1,
    MASK_X = 2'd2
  } MASK_SEL;

  // Drain FSM states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } STORE_STATE;

  // Byte-lane strobes before shifting into position.
  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/riscv_store_align.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_store_align
//  Description : Combinational lane aligner. Moves the low byte/half/word of
//                the store data into the byte lanes selected by the address
//                offset and builds the matching strobes. Flags misaligned
//                halfword/word stores and unknown width encodings.
//  Ports       : addr_off_i  - st_addr[1:0]
//                data_i      - zero-extended store data
//                mask_sel_i  - store width select
//                wdata_o     - lane-aligned write data
//                wstrb_o     - byte strobes
//                fault_o     - store is misaligned or illegal
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_store_align
  import riscv_store_pkg::*;
#(
  parameter int WORD_LENGTH = 32
) (
  input  logic [1:0]               addr_off_i,
  input  logic [WORD_LENGTH-1:0]   data_i,
  input  logic [MASK_SEL_W-1:0]    mask_sel_i,
  output logic [WORD_LENGTH-1:0]   wdata_o,
  output logic [WORD_LENGTH/8-1:0] wstrb_o,
  output logic                     fault_o
);

  always_comb begin
    wdata_o = '0;
    wstrb_o = '0;
    fault_o = 1'b1;
    case (mask_sel_i)
      MASK_B: begin
        wdata_o = data_i << {addr_off_i, 3'b000};
        wstrb_o = STRB_B << addr_off_i;
        fault_o = 1'b0;
      end
      MASK_H: begin
        wdata_o = data_i << {addr_off_i, 3'b000};
        wstrb_o = STRB_H << addr_off_i;
        fault_o = addr_off_i[0];
      end
      MASK_X: begin
        wdata_o = data_i;
        wstrb_o = STRB_W;
        fault_o = (addr_off_i != 2'b00);
      end
      default: begin
        // Unknown width encoding: zero data/strobes, fault raised.
        wdata_o = '0;
        wstrb_o = '0;
        fault_o = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/riscv_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_store_unit
//  Description : Store path stage. Aligns incoming stores, buffers legal ones
//                in a DEPTH-entry circular queue and drains them to data
//                memory over a req/ack handshake. Faulting stores complete
//                the handshake but are dropped with a one-cycle st_fault.
//  Ports       : clk, rst            - clock, async active-high reset
//                st_valid/st_ready   - store input handshake
//                st_addr/st_data     - effective address, masked data
//                st_mask_sel         - store width
//                st_fault            - pulse after a faulting accept
//                mem_req/mem_ack     - memory write handshake
//                mem_addr/mem_wdata/mem_wstrb - head-of-queue write
//                busy                - queue non-empty
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_store_unit
  import riscv_store_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_LENGTH = 32,
  parameter int DEPTH       = 2    // power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_LENGTH-1:0]   st_addr,
  input  logic [WORD_LENGTH-1:0]   st_data,
  input  logic [MASK_SEL_W-1:0]    st_mask_sel,
  output logic                     st_fault,
  output logic                     mem_req,
  output logic [ADDR_LENGTH-1:0]   mem_addr,
  output logic [WORD_LENGTH-1:0]   mem_wdata,
  output logic [WORD_LENGTH/8-1:0] mem_wstrb,
  input  logic                     mem_ack,
  output logic                     busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BYTES = WORD_LENGTH / 8;
  localparam int WADR_W = ADDR_LENGTH - 2;

  // --------------------------------------------------------------------------
  // Alignment
  // --------------------------------------------------------------------------
  logic [WORD_LENGTH-1:0] al_wdata;
  logic [BYTES-1:0]       al_wstrb;
  logic                   al_fault;

  riscv_store_align #(
    .WORD_LENGTH (WORD_LENGTH)
  ) u_align (
    .addr_off_i (st_addr[1:0]),
    .data_i     (st_data),
    .mask_sel_i (st_mask_sel),
    .wdata_o    (al_wdata),
    .wstrb_o    (al_wstrb),
    .fault_o    (al_fault)
  );

  // --------------------------------------------------------------------------
  // Queue storage and pointers
  // --------------------------------------------------------------------------
  logic [WADR_W-1:0]      addr_mem_q [DEPTH];
  logic [WORD_LENGTH-1:0] data_mem_q [DEPTH];
  logic [BYTES-1:0]       strb_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, remain;

  STORE_STATE       state_q;
  logic             mem_req_q;
  logic             st_fault_q;
  logic [WADR_W-1:0]      out_addr_q;
  logic [WORD_LENGTH-1:0] out_wdata_q;
  logic [BYTES-1:0]       out_wstrb_q;

  logic accept, enq, pop;

  // Full depends on registered count only: a same-cycle ack does not open
  // a slot until the following cycle.
  assign st_ready = (count_q != CNT_W'(DEPTH));
  assign accept   = st_valid && st_ready;
  assign enq      = accept && !al_fault;
  // mem_req_q is high exactly in ST_REQ, so an ack outside REQ is ignored.
  assign pop      = mem_req_q && mem_ack;

  assign count_d  = count_q + CNT_W'(enq) - CNT_W'(pop);
  assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  // Entries left from before this cycle once the pop is accounted for.
  assign remain   = count_q - CNT_W'(pop);

  // Head of the queue as it will be after this edge. When the old contents
  // are exhausted the new head is the store being written this cycle,
  // which is not yet visible in the storage array.
  logic [WADR_W-1:0]      head_addr;
  logic [WORD_LENGTH-1:0] head_wdata;
  logic [BYTES-1:0]       head_wstrb;

  always_comb begin
    head_addr  = addr_mem_q[rd_ptr_d];
    head_wdata = data_mem_q[rd_ptr_d];
    head_wstrb = strb_mem_q[rd_ptr_d];
    if (remain == '0) begin
      head_addr  = st_addr[ADDR_LENGTH-1:2];
      head_wdata = al_wdata;
      head_wstrb = al_wstrb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
        strb_mem_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        addr_mem_q[wr_ptr_q] <= st_addr[ADDR_LENGTH-1:2];
        data_mem_q[wr_ptr_q] <= al_wdata;
        strb_mem_q[wr_ptr_q] <= al_wstrb;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Drain FSM with registered request outputs
  // --------------------------------------------------------------------------
  // Output registers load the post-edge head whenever the FSM is (or stays)
  // in REQ; without an ack the head is unchanged so the outputs are stable.
  // In IDLE they simply hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      st_fault_q  <= 1'b0;
      out_addr_q  <= '0;
      out_wdata_q <= '0;
      out_wstrb_q <= '0;
    end else begin
      st_fault_q <= accept && al_fault;
      case (state_q)
        ST_IDLE: begin
          if ((count_q != '0) || enq) begin
            state_q     <= ST_REQ;
            mem_req_q   <= 1'b1;
            out_addr_q  <= head_addr;
            out_wdata_q <= head_wdata;
            out_wstrb_q <= head_wstrb;
          end
        end
        ST_REQ: begin
          if (count_d != '0) begin
            out_addr_q  <= head_addr;
            out_wdata_q <= head_wdata;
            out_wstrb_q <= head_wstrb;
          end else begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = {out_addr_q, 2'b00};
  assign mem_wdata = out_wdata_q;
  assign mem_wstrb = out_wstrb_q;
  assign st_fault  = st_fault_q;
  assign busy      = (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_riscv_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_store_unit
//  Description : Scoreboard bench for riscv_store_unit. Stimulus pushes the
//                expected memory write (from a byte-lane reference model)
//                into a queue; a monitor compares every presented request
//                against the queue head and pops on ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_store_unit;
  import riscv_store_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [1:0]  st_mask_sel = '0;
  logic        st_fault;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic        busy;

  riscv_store_unit #(
    .WORD_LENGTH (32),
    .ADDR_LENGTH (32),
    .DEPTH       (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_mask_sel (st_mask_sel),
    .st_fault    (st_fault),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ack     (mem_ack),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } ent_t;

  ent_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_fault;
  bit   ack_rand = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference rules: bytes touched = width, starting at the address offset.
  function automatic bit is_legal(logic [1:0] off, logic [1:0] sel);
    case (sel)
      2'd0:    return 1'b1;
      2'd1:    return (off % 2) == 0;
      2'd2:    return off == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ent_t model(logic [31:0] a, logic [31:0] d, logic [1:0] sel);
    ent_t e;
    int   size;
    int   off;
    off  = int'(a % 4);
    size = (sel == 2'd0) ? 1 : (sel == 2'd1) ? 2 : 4;
    e.addr  = a - a % 4;
    e.wdata = '0;
    e.wstrb = '0;
    for (int b = 0; b < size; b++) begin
      e.wdata[8*(off+b) +: 8] = d[8*b +: 8];
      e.wstrb[off+b]          = 1'b1;
    end
    return e;
  endfunction

  // Expected fault pulse: one cycle after a faulting handshake.
  always @(posedge clk or posedge rst) begin
    if (rst) exp_fault <= 1'b0;
    else     exp_fault <= st_valid && st_ready && !is_legal(st_addr[1:0], st_mask_sel);
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      chk("st_fault", {31'd0, st_fault}, {31'd0, exp_fault});
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: got addr 0x%08h with empty scoreboard at %0t", mem_addr, $time);
        end else begin
          chk("mem_addr",  mem_addr,  exp_q[0].addr);
          chk("mem_wdata", mem_wdata, exp_q[0].wdata);
          chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_q[0].wstrb});
          if (mem_ack) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Randomised memory ack during the random phase.
  always @(posedge clk) begin
    if (ack_rand) begin
      #1;
      mem_ack = ($urandom_range(0, 2) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sel);
    int n;
    n = 0;
    st_valid    = 1'b1;
    st_addr     = a;
    st_data     = d;
    st_mask_sel = sel;
    while (!st_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!st_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: st_ready stayed 0 for %0d cycles, required 1", n);
    end else if (is_legal(a[1:0], sel)) begin
      exp_q.push_back(model(a, d, sel));
    end
    @(posedge clk);
    #1;
    st_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((busy || mem_req) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
    int          r;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_st_ready",  {31'd0, st_ready}, 32'd1);
    chk("rst_st_fault",  {31'd0, st_fault}, 32'd0);
    chk("rst_mem_req",   {31'd0, mem_req},  32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_mem_addr",  mem_addr,  32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_busy",      {31'd0, busy},     32'd0);

    // SB at offset 3, zero-wait memory: request appears the next cycle.
    mem_ack = 1'b1;
    send(32'h0000_1003, 32'h0000_00AB, MASK_B);
    chk("sb_req",   {31'd0, mem_req}, 32'd1);
    chk("sb_addr",  mem_addr, 32'h0000_1000);
    chk("sb_wstrb", {28'd0, mem_wstrb}, 32'h8);
    chk("sb_wdata", mem_wdata, 32'hAB00_0000);
    wait_idle(10);

    // SH at offset 2
    send(32'h0000_2002, 32'h0000_BEEF, MASK_H);
    chk("sh_wstrb", {28'd0, mem_wstrb}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hBEEF_0000);
    wait_idle(10);

    // Misaligned SH: fault for exactly one cycle, no request.
    send(32'h0000_2001, 32'h0000_1234, MASK_H);
    chk("shmis_fault", {31'd0, st_fault}, 32'd1);
    chk("shmis_req",   {31'd0, mem_req},  32'd0);
    @(posedge clk);
    #1;
    chk("shmis_fault_end", {31'd0, st_fault}, 32'd0);
    chk("shmis_busy",      {31'd0, busy},     32'd0);

    // SW with 5-cycle stall
    mem_ack = 1'b0;
    send(32'h0000_3000, 32'hCAFE_F00D, MASK_X);
    repeat (5) begin
      chk("stall_req",   {31'd0, mem_req}, 32'd1);
      chk("stall_addr",  mem_addr, 32'h0000_3000);
      chk("stall_wdata", mem_wdata, 32'hCAFE_F00D);
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b1;
    chk("stall_busy_ack", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    chk("stall_busy_after", {31'd0, busy},    32'd0);
    chk("stall_req_after",  {31'd0, mem_req}, 32'd0);

    // Three back-to-back SW with memory stalled: back-pressure after two.
    fork
      begin
        send(32'h0000_4000, 32'h1111_1111, MASK_X);
        send(32'h0000_4004, 32'h2222_2222, MASK_X);
        send(32'h0000_4008, 32'h3333_3333, MASK_X);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("bp_ready_low", {31'd0, st_ready}, 32'd0);
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_ready_after_ack", {31'd0, st_ready}, 32'd1);
        chk("bp_third_offered",   {31'd0, st_valid}, 32'd1);
      end
    join
    wait_idle(20);

    // Reset with two entries queued and a request outstanding.
    mem_ack = 1'b0;
    send(32'h0000_5000, 32'h5555_AAAA, MASK_X);
    send(32'h0000_5004, 32'hAAAA_5555, MASK_X);
    chk("prerst_req",  {31'd0, mem_req},  32'd1);
    chk("prerst_full", {31'd0, st_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("midrst_req",  {31'd0, mem_req}, 32'd0);
    chk("midrst_busy", {31'd0, busy},    32'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    mem_ack = 1'b1;
    repeat (5) begin
      chk("postrst_req", {31'd0, mem_req}, 32'd0);
      @(posedge clk);
      #1;
    end

    // Illegal width encoding: fault, queue untouched.
    send(32'h0000_0000, 32'h0BAD_0BAD, 2'd3);
    chk("illegal_fault", {31'd0, st_fault}, 32'd1);
    chk("illegal_busy",  {31'd0, busy},     32'd0);
    chk("illegal_req",   {31'd0, mem_req},  32'd0);

    // Random traffic with random memory wait states.
    ack_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      s = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        if (s == 2'd1) a[0] = 1'b0;
        if (s == 2'd2) a[1:0] = 2'b00;
      end
      d = $urandom;
      if (s == 2'd0) d = d & 32'h0000_00FF;
      if (s == 2'd1) d = d & 32'h0000_FFFF;
      send(a, d, s);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    ack_rand = 1'b0;
    @(posedge clk);
    #2;
    mem_ack = 1'b1;
    wait_idle(50);
    @(posedge clk);
    #1;
    chk("final_scoreboard_empty", exp_q.size(), 32'd0);
    chk("final_req", {31'd0, mem_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
